// File: rtl/uart_rx_display_buffer.sv
// Receive-byte front end for the four-digit LED display: edge-detects Rx_VALID,
// drops errored bytes, shifts good bytes into a hex window and tracks error stats.
module uart_rx_display_buffer #(
  parameter logic [7:0]  CLR_CODE = 8'h1B,
  parameter int unsigned ERR_HOLD = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  Rx_DATA,
  input  logic        Rx_VALID,
  input  logic        Rx_FERROR,
  input  logic        Rx_PERROR,
  output logic [15:0] Data_out,
  output logic [3:0]  Blank,
  output logic        Err_flag,
  output logic [7:0]  Err_count,
  output logic [7:0]  Byte_count
);

  // State encoding doubles as the blank mask, so Blank is a plain register decode.
  typedef enum logic [3:0] {
    EMPTY = 4'b1111,
    HALF  = 4'b1100,
    FULL  = 4'b0000
  } fill_e;

  localparam logic [15:0] HOLD_LD = 16'(ERR_HOLD);

  fill_e       state, state_nxt;
  logic        valid_d;
  logic [15:0] hold_cnt;
  logic        ev, is_err, is_clr, is_data;

  assign ev      = Rx_VALID & ~valid_d;
  assign is_err  = ev & (Rx_FERROR | Rx_PERROR);
  assign is_clr  = ev & ~is_err & (Rx_DATA == CLR_CODE);
  assign is_data = ev & ~is_err & (Rx_DATA != CLR_CODE);

  // valid_d keeps following Rx_VALID through reset so a byte still presented
  // when reset releases is not mistaken for a new one.
  always_ff @(posedge clk) valid_d <= Rx_VALID;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (is_clr) begin
      state_nxt = EMPTY;
    end else if (is_data) begin
      case (state)
        EMPTY:   state_nxt = HALF;
        HALF:    state_nxt = FULL;
        default: state_nxt = FULL;
      endcase
    end
  end

  assign Blank = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      Data_out   <= 16'h0000;
      Byte_count <= 8'd0;
    end else if (is_clr) begin
      Data_out   <= 16'h0000;
    end else if (is_data) begin
      Data_out   <= {Data_out[7:0], Rx_DATA};
      Byte_count <= Byte_count + 8'd1;
    end
  end

  // Flag is registered alongside the counter and drops the cycle the counter hits 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt  <= 16'd0;
      Err_flag  <= 1'b0;
      Err_count <= 8'd0;
    end else if (is_err) begin
      hold_cnt  <= HOLD_LD;
      Err_flag  <= 1'b1;
      if (Err_count != 8'hFF) Err_count <= Err_count + 8'd1;
    end else if (hold_cnt != 16'd0) begin
      hold_cnt  <= hold_cnt - 16'd1;
      Err_flag  <= (hold_cnt > 16'd1);
    end else begin
      Err_flag  <= 1'b0;
    end
  end

endmodule
